m_store_unit: RTL and testbench
===============================

Name: m_store_unit

Overview:
Store-side counterpart of the M-stage load data extender. It takes sw/sh/sb requests from the M stage, forms the word address, byte enables and lane-replicated write data, and queues them in an in-order write buffer. The buffer drains to data memory over a req/ack handshake. A word-address match port lets the hazard unit stall loads that hit a pending store.

Parameters:
DEPTH, 4, write-buffer entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
M_StoreValid  input  1  store request valid
M_StoreReady  output  1  buffer can accept a request this cycle
M_StoreAddr  input  32  byte address
M_StoreData  input  32  rt value, unaligned
M_StoreOp  input  2  00 SW, 01 SH, 10 SB, 11 reserved
M_Misaligned  output  1  one-cycle pulse: accepted request was dropped
M_LoadAddr  input  32  load byte address from M stage
M_LoadHit  output  1  a pending entry has the same word address
M_BufEmpty  output  1  no pending entries
Mem_WrReq  output  1  head entry presented to memory
Mem_WrAddr  output  32  word address {addr[31:2],2'b00}
Mem_WrData  output  32  lane-replicated data
Mem_ByteEn  output  4  byte enables, bit i = byte lane i
Mem_WrAck  input  1  memory accepted head entry at this edge

Behaviour:
- Reset (reset_n low, takes effect immediately): count=0, pointers=0, all entries invalid, M_Misaligned=0. While reset_n is low: Mem_WrReq=0, M_BufEmpty=1, M_LoadHit=0, M_StoreReady=0. Pending stores are discarded mid-drain and are never completed.
- Accept: a request is accepted when M_StoreValid && M_StoreReady at the rising edge. M_StoreReady = reset_n && (count != DEPTH). There is no full-bypass path.
- Format rules, applied at enqueue:
  - SW: addr[1:0] must be 0. ByteEn=1111. Data=StoreData.
  - SH: addr[0] must be 0. ByteEn=0011 if addr[1]=0, 1100 if addr[1]=1. Data={d[15:0],d[15:0]}.
  - SB: ByteEn=0001<<addr[1:0]. Data={4{d[7:0]}}.
- Misaligned request or Op=11: handshake still completes but nothing is enqueued. M_Misaligned=1 for exactly the following cycle.
- FIFO: in-order only, with no coalescing or merging.
  - Enqueue writes at the tail; the tail wraps from DEPTH-1 to 0.
  - Pop happens on Mem_WrAck && Mem_WrReq; the head wraps the same way.
  - Push and pop in the same cycle leave count unchanged.
  - A push into an empty buffer is presented on Mem_Wr* in the next cycle, giving 1-cycle minimum latency.
- Drain FSM:
  - IDLE (count==0): Mem_WrReq=0. Move to REQ on the next edge after a push.
  - REQ: Mem_WrReq=1, and Mem_WrAddr/Data/ByteEn show the head entry, held stable until ack.
  - On ack: return to IDLE if count becomes 0, otherwise stay in REQ and present the next entry the following cycle.
  - Mem_WrAck is ignored in IDLE.
- M_LoadHit: combinational. Set when any valid entry's word address equals M_LoadAddr[31:2]. This includes the head during its ack cycle. A request being enqueued in the same cycle is excluded.
- M_BufEmpty = (count==0).
- Mem_Wr* outputs are 0 when Mem_WrReq=0.

Test Plan:
- Reset, then SW addr 0x100 data 0xDEADBEEF with ack held 1 -> next cycle WrReq=1, WrAddr=0x100, ByteEn=1111, Data=0xDEADBEEF; popped at that edge; BufEmpty=1 after.
- SH 0x102 data 0x1234ABCD, then SB 0x203 data 0x000000EE, ack held 0 -> head ByteEn=1100, Data=0xABCDABCD; after ack, ByteEn=1000, Data=0xEEEEEEEE, WrAddr=0x200.
- Ack 0, push 4 stores -> Ready=0 after the 4th, a 5th Valid is not accepted; one ack -> Ready=1 next cycle; order is preserved across pointer wrap.
- SW at 0x101, then SH at 0x103 -> one-cycle Misaligned pulse for each, count stays 0, no WrReq.
- Pending SB at 0x1FF, LoadAddr=0x1FC -> LoadHit=1; LoadAddr=0x200 -> LoadHit=0.
- Two entries pending, WrReq=1, reset_n pulsed low mid-cycle -> WrReq=0 immediately; after release BufEmpty=1 and no stale write appears.

Source files
------------

// File: rtl/m_store_unit.sv
// Store unit for the M stage: formats sw/sh/sb requests into word address, byte enables and
// lane-replicated data, then drains them in order from a small write buffer to data memory.
module m_store_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M_StoreValid,
    output logic        M_StoreReady,
    input  logic [31:0] M_StoreAddr,
    input  logic [31:0] M_StoreData,
    input  logic [1:0]  M_StoreOp,
    output logic        M_Misaligned,
    input  logic [31:0] M_LoadAddr,
    output logic        M_LoadHit,
    output logic        M_BufEmpty,
    output logic        Mem_WrReq,
    output logic [31:0] Mem_WrAddr,
    output logic [31:0] Mem_WrData,
    output logic [3:0]  Mem_ByteEn,
    input  logic        Mem_WrAck,
    output logic        dbg_drain_state
);

    // Handshakes: M side transfers when M_StoreValid && M_StoreReady at a rising edge;
    // memory side transfers when Mem_WrReq && Mem_WrAck at a rising edge. Req/data hold until ack.

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} drain_state_e;

    typedef struct packed {
        logic        vld;
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t       buf_q [DEPTH];
    entry_t       buf_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             mis_q, mis_d;
    drain_state_e     state_q, state_d;

    logic        fmt_ok;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_data;
    logic        push_req, push, pop;
    logic        unused_load_lsb;

    assign unused_load_lsb = ^M_LoadAddr[1:0];

    always_comb begin
        fmt_ok   = 1'b0;
        fmt_be   = 4'b0000;
        fmt_data = M_StoreData;
        case (M_StoreOp)
            2'b00: begin
                fmt_ok = (M_StoreAddr[1:0] == 2'b00);
                fmt_be = 4'b1111;
            end
            2'b01: begin
                fmt_ok   = !M_StoreAddr[0];
                fmt_be   = M_StoreAddr[1] ? 4'b1100 : 4'b0011;
                fmt_data = {M_StoreData[15:0], M_StoreData[15:0]};
            end
            2'b10: begin
                fmt_ok   = 1'b1;
                fmt_be   = 4'b0001 << M_StoreAddr[1:0];
                fmt_data = {4{M_StoreData[7:0]}};
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    assign M_StoreReady = reset_n && (count_q != (PTR_W+1)'(DEPTH));
    assign Mem_WrReq    = reset_n && (state_q == S_REQ);
    assign push_req     = M_StoreValid && M_StoreReady;
    assign push         = push_req && fmt_ok;
    assign pop          = Mem_WrReq && Mem_WrAck;

    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mis_d   = push_req && !fmt_ok;
        // head and tail only coincide when empty (no pop) or full (no push)
        if (pop) begin
            buf_d[head_q].vld = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
        if (push) begin
            buf_d[tail_q] = '{vld: 1'b1, waddr: M_StoreAddr[31:2], data: fmt_data, be: fmt_be};
            tail_d        = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (push) state_d = S_REQ;
            S_REQ:   if (pop && (count_d == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mis_q   <= mis_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        M_LoadHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_q[i].vld && (buf_q[i].waddr == M_LoadAddr[31:2])) M_LoadHit = reset_n;
        end
    end

    assign M_Misaligned    = mis_q;
    assign M_BufEmpty      = (count_q == '0);
    assign Mem_WrAddr      = Mem_WrReq ? {buf_q[head_q].waddr, 2'b00} : 32'h0;
    assign Mem_WrData      = Mem_WrReq ? buf_q[head_q].data : 32'h0;
    assign Mem_ByteEn      = Mem_WrReq ? buf_q[head_q].be : 4'h0;
    assign dbg_drain_state = state_q;

endmodule

// File: tb/tb_m_store_unit.sv
// Directed bench for m_store_unit: stimulus pushes hand-computed writes into exp_q, and a
// negedge monitor pops and compares every write the unit hands to memory.
module tb_m_store_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_StoreValid = 1'b0;
  logic        M_StoreReady;
  logic [31:0] M_StoreAddr = '0;
  logic [31:0] M_StoreData = '0;
  logic [1:0]  M_StoreOp = '0;
  logic        M_Misaligned;
  logic [31:0] M_LoadAddr = '0;
  logic        M_LoadHit;
  logic        M_BufEmpty;
  logic        Mem_WrReq;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [3:0]  Mem_ByteEn;
  logic        Mem_WrAck = 1'b0;
  logic        dbg_drain_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [67:0] exp_q[$];

  m_store_unit #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .M_StoreValid(M_StoreValid), .M_StoreReady(M_StoreReady),
    .M_StoreAddr(M_StoreAddr), .M_StoreData(M_StoreData), .M_StoreOp(M_StoreOp),
    .M_Misaligned(M_Misaligned), .M_LoadAddr(M_LoadAddr), .M_LoadHit(M_LoadHit),
    .M_BufEmpty(M_BufEmpty), .Mem_WrReq(Mem_WrReq), .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData), .Mem_ByteEn(Mem_ByteEn), .Mem_WrAck(Mem_WrAck),
    .dbg_drain_state(dbg_drain_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one request from posedge+1; it is accepted at the next rising edge
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op,
                       input logic [3:0] exp_be, input logic [31:0] exp_data, input bit ok);
    M_StoreValid = 1'b1;
    M_StoreAddr  = addr;
    M_StoreData  = data;
    M_StoreOp    = op;
    @(negedge clk);
    check("store_ready", M_StoreReady, 1);
    if (ok) exp_q.push_back({addr[31:2], 2'b00, exp_data, exp_be});
    @(posedge clk);
    #1;
    M_StoreValid = 1'b0;
    check("misaligned_pulse", M_Misaligned, !ok);
  endtask

  task automatic wait_empty(input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      step();
      if (M_BufEmpty) done = 1;
    end
    check("drain_timeout", done, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (Mem_WrReq) begin
        if (Mem_WrAck) begin
          if (exp_q.size() == 0) begin
            check("stale_write", 1, 0);
          end else begin
            check("mem_write", {Mem_WrAddr, Mem_WrData, Mem_ByteEn}, exp_q.pop_front());
          end
        end
      end else begin
        check("idle_outputs_zero", {Mem_WrAddr, Mem_WrData, Mem_ByteEn}, 0);
      end
    end
  end

  initial begin
    // reset state
    M_LoadAddr = 32'h0000_0100;
    #2;
    check("rst_wrreq", Mem_WrReq, 0);
    check("rst_empty", M_BufEmpty, 1);
    check("rst_ready", M_StoreReady, 0);
    check("rst_loadhit", M_LoadHit, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", M_StoreReady, 1);
    check("post_rst_mis", M_Misaligned, 0);
    check("post_rst_empty", M_BufEmpty, 1);
    step();

    // SW with ack held high: one-cycle latency, popped immediately
    Mem_WrAck = 1'b1;
    store(32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 4'b1111, 32'hDEAD_BEEF, 1);
    check("t1_wrreq", Mem_WrReq, 1);
    check("t1_addr", Mem_WrAddr, 32'h0000_0100);
    check("t1_data", Mem_WrData, 32'hDEAD_BEEF);
    check("t1_be", Mem_ByteEn, 4'b1111);
    step();
    check("t1_empty_after", M_BufEmpty, 1);
    check("t1_wrreq_after", Mem_WrReq, 0);

    // SH upper half then SB lane 3, held until ack
    Mem_WrAck = 1'b0;
    store(32'h0000_0102, 32'h1234_ABCD, 2'b01, 4'b1100, 32'hABCD_ABCD, 1);
    store(32'h0000_0203, 32'h0000_00EE, 2'b10, 4'b1000, 32'hEEEE_EEEE, 1);
    check("t2_head_be", Mem_ByteEn, 4'b1100);
    check("t2_head_data", Mem_WrData, 32'hABCD_ABCD);
    step();
    step();
    check("t2_head_stable", {Mem_WrAddr, Mem_WrData, Mem_ByteEn}, {32'h0000_0100, 32'hABCD_ABCD, 4'b1100});
    Mem_WrAck = 1'b1;
    step();
    check("t2_second_addr", Mem_WrAddr, 32'h0000_0200);
    check("t2_second_be", Mem_ByteEn, 4'b1000);
    wait_empty(10);
    Mem_WrAck = 1'b0;

    // fill to DEPTH across pointer wrap, refuse a fifth, free one slot
    store(32'h0000_0300, 32'h1111_1111, 2'b00, 4'b1111, 32'h1111_1111, 1);
    store(32'h0000_0304, 32'h0000_0022, 2'b10, 4'b0001, 32'h2222_2222, 1);
    store(32'h0000_030A, 32'h5555_3333, 2'b01, 4'b1100, 32'h3333_3333, 1);
    store(32'h0000_030C, 32'h4444_4444, 2'b00, 4'b1111, 32'h4444_4444, 1);
    check("t3_full_ready", M_StoreReady, 0);
    M_StoreValid = 1'b1;
    M_StoreAddr  = 32'h0000_0310;
    M_StoreData  = 32'h9999_9999;
    M_StoreOp    = 2'b00;
    step();
    step();
    check("t3_full_still", M_StoreReady, 0);
    M_StoreValid = 1'b0;
    Mem_WrAck = 1'b1;
    step();
    Mem_WrAck = 1'b0;
    check("t3_ready_after_ack", M_StoreReady, 1);
    store(32'h0000_0310, 32'h5555_5555, 2'b00, 4'b1111, 32'h5555_5555, 1);
    Mem_WrAck = 1'b1;
    wait_empty(20);
    Mem_WrAck = 1'b0;

    // misaligned and reserved requests are dropped
    store(32'h0000_0101, 32'h0000_0011, 2'b00, 4'b0000, 32'h0, 0);
    step();
    check("t4_mis_clear", M_Misaligned, 0);
    check("t4_empty", M_BufEmpty, 1);
    store(32'h0000_0103, 32'h0000_0022, 2'b01, 4'b0000, 32'h0, 0);
    check("t4_no_req", Mem_WrReq, 0);
    step();
    check("t4_mis_clear2", M_Misaligned, 0);
    store(32'h0000_0100, 32'h0000_0033, 2'b11, 4'b0000, 32'h0, 0);
    step();
    check("t4_empty_end", M_BufEmpty, 1);

    // load hit on the pending word, not on the one being enqueued
    M_LoadAddr   = 32'h0000_01FC;
    M_StoreValid = 1'b1;
    M_StoreAddr  = 32'h0000_01FF;
    M_StoreData  = 32'h0000_0077;
    M_StoreOp    = 2'b10;
    #1;
    check("t5_hit_excl_enq", M_LoadHit, 0);
    store(32'h0000_01FF, 32'h0000_0077, 2'b10, 4'b1000, 32'h7777_7777, 1);
    check("t5_hit", M_LoadHit, 1);
    M_LoadAddr = 32'h0000_01FF;
    #1;
    check("t5_hit_same_word", M_LoadHit, 1);
    M_LoadAddr = 32'h0000_0200;
    #1;
    check("t5_miss_next", M_LoadHit, 0);
    M_LoadAddr = 32'h0000_01F8;
    #1;
    check("t5_miss_prev", M_LoadHit, 0);
    M_LoadAddr = 32'h0000_01FC;
    Mem_WrAck = 1'b1;
    @(negedge clk);
    check("t5_hit_ack_cycle", M_LoadHit, 1);
    @(posedge clk);
    #1;
    Mem_WrAck = 1'b0;
    check("t5_hit_gone", M_LoadHit, 0);
    check("t5_empty", M_BufEmpty, 1);

    // reset mid-drain discards pending stores
    store(32'h0000_0400, 32'hAAAA_AAAA, 2'b00, 4'b1111, 32'hAAAA_AAAA, 1);
    store(32'h0000_0404, 32'hBBBB_BBBB, 2'b00, 4'b1111, 32'hBBBB_BBBB, 1);
    check("t6_wrreq", Mem_WrReq, 1);
    M_LoadAddr = 32'h0000_0400;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_wrreq", Mem_WrReq, 0);
    check("t6_rst_empty", M_BufEmpty, 1);
    check("t6_rst_ready", M_StoreReady, 0);
    check("t6_rst_hit", M_LoadHit, 0);
    exp_q.delete();
    Mem_WrAck = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_empty_after", M_BufEmpty, 1);
      check("t6_no_stale_req", Mem_WrReq, 0);
    end
    Mem_WrAck = 1'b0;
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
